// File: rtl/hdv_deadlock_watchdog_if.sv
// Signal bundle between the kernel-monitor top and one deadlock watchdog.
// No valid/ready handshake: every input is a level sampled on each clock edge, and every output is a registered level.
interface hdv_deadlock_watchdog_if #(
  parameter int N_AXIS = 1,
  parameter int N_INST = 2,
  parameter int N_BLK  = 1,
  parameter int CNT_W  = 16,
  parameter int ID_W   = 4
);
  logic [N_AXIS-1:0] axis_block_sigs;
  logic [N_INST-1:0] inst_idle_sigs;
  logic [N_BLK-1:0]  inst_block_sigs;
  logic              clear;
  logic              block;
  logic [ID_W-1:0]   block_id;
  logic [CNT_W-1:0]  block_cycles;
  logic [1:0]        state;

  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    input  block, block_id, block_cycles, state
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    output block, block_id, block_cycles, state
  );
endinterface

// File: rtl/hdv_deadlock_watchdog.sv
// Per-kernel deadlock judge: a stall vector that stays unchanged for THRESH cycles latches a sticky verdict.
// The verdict also records the culprit index and counts the stalled cycles since it rose.
module hdv_deadlock_watchdog #(
  parameter int N_AXIS = 1,
  parameter int N_INST = 2,
  parameter int N_BLK  = 1,
  parameter int THRESH = 1024,
  parameter int CNT_W  = 16,
  parameter int ID_W   = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  hdv_deadlock_watchdog_if.slave bus
);
  localparam int N_VEC = N_AXIS + N_BLK;
  localparam int TH    = (THRESH < 1) ? 1 : THRESH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WATCH   = 2'd1,
    S_BLOCKED = 2'd2
  } state_t;

  state_t            r_state;
  logic [N_VEC-1:0]  r_snap;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_block;
  logic [ID_W-1:0]   r_block_id;
  logic [CNT_W-1:0]  r_block_cycles;

  logic [N_VEC-1:0]  w_vec;
  logic [N_INST-1:0] w_idle;
  logic              w_cond;

  // Axis taps sit in the low bits, so their indices come first in block_id.
  assign w_vec  = {bus.inst_block_sigs, bus.axis_block_sigs};
  assign w_idle = bus.inst_idle_sigs;
  assign w_cond = (|w_vec) && !(&w_idle);

  function automatic logic [ID_W-1:0] lowest_idx(input logic [N_VEC-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = N_VEC - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_snap         <= '0;
      r_cnt          <= '0;
      r_block        <= 1'b0;
      r_block_id     <= '0;
      r_block_cycles <= '0;
    end else if (bus.clear) begin
      // block_id is held so the diagnosis report still names the last culprit.
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_block        <= 1'b0;
      r_block_cycles <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cond) begin
            r_snap <= w_vec;
            if (TH == 1) begin
              r_state        <= S_BLOCKED;
              r_block        <= 1'b1;
              r_block_id     <= lowest_idx(w_vec);
              r_block_cycles <= '0;
              r_cnt          <= '0;
            end else begin
              r_state <= S_WATCH;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        S_WATCH: begin
          if (!w_cond || (w_vec != r_snap)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state        <= S_BLOCKED;
            r_block        <= 1'b1;
            r_block_id     <= lowest_idx(r_snap);
            r_block_cycles <= '0;
            r_cnt          <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_BLOCKED: begin
          if (r_block_cycles != CNT_MAX) r_block_cycles <= r_block_cycles + CNT_W'(1);
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.block        = r_block;
  assign bus.block_id     = r_block_id;
  assign bus.block_cycles = r_block_cycles;
  assign bus.state        = r_state;
endmodule
